// File: rtl/bmc_pkg.sv
// rtl/bmc_pkg.sv - shared types and OSR-derived thresholds for the biphase-mark receiver
package bmc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CELL = 2'd1,
    MID  = 2'd2
  } bmc_state_e;

  typedef enum logic [1:0] {
    SHORT   = 2'd0,
    LONG    = 2'd1,
    ILLEGAL = 2'd2
  } bmc_interval_e;

  function automatic int short_min(input int osr);
    return osr / 4;
  endfunction

  function automatic int long_min(input int osr);
    return (3 * osr) / 4;
  endfunction

  function automatic int long_max(input int osr);
    return (5 * osr) / 4;
  endfunction

  function automatic int frame_gap(input int osr);
    return 2 * osr;
  endfunction

  function automatic int timeout_count(input int osr);
    return 2 * osr + 1;
  endfunction

  // n is the edge-to-edge spacing in clock cycles
  function automatic bmc_interval_e classify(input int n, input int osr);
    if (n >= short_min(osr) && n < long_min(osr)) begin
      return SHORT;
    end else if (n >= long_min(osr) && n <= long_max(osr)) begin
      return LONG;
    end else begin
      return ILLEGAL;
    end
  endfunction

endpackage

// File: rtl/bmc_edge_sync.sv
// rtl/bmc_edge_sync.sv - two-flop synchronizer plus transition detector for the serial line
module bmc_edge_sync (
  input  logic clock,
  input  logic reset,
  input  logic serial_in,
  output logic line_edge
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = serial_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // high for the one cycle in which the synchronized level differs from the last one
  assign line_edge = sync2_q ^ prev_q;

endmodule

// File: rtl/bmc_receiver.sv
// rtl/bmc_receiver.sv - biphase-mark decoder with framing, error pulses and a one-word output slot
module bmc_receiver
  import bmc_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OSR   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             serial_in,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             overrun,
  output logic             code_error,
  output logic             frame_error
);

  localparam int CNT_W = $clog2(2 * OSR + 2);
  localparam int BIT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(timeout_count(OSR));
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(frame_gap(OSR));
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WIDTH - 1);

  logic line_edge;

  bmc_edge_sync u_edge_sync (
    .clock     (clock),
    .reset     (reset),
    .serial_in (serial_in),
    .line_edge (line_edge)
  );

  bmc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             overrun_q, overrun_d;
  logic             code_error_q, code_error_d;
  logic             frame_error_q, frame_error_d;

  bmc_interval_e    edge_class;
  logic             bit_strobe;
  logic             bit_value;
  logic             handshake;

  always_comb begin
    edge_class    = classify(int'(cnt_q) + 1, OSR);
    cnt_d         = line_edge ? '0 : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1));
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    done_d        = 1'b0;
    code_error_d  = 1'b0;
    frame_error_d = 1'b0;
    bit_strobe    = 1'b0;
    bit_value     = 1'b0;

    case (state_q)
      IDLE: begin
        // only an edge after a long quiet line marks the start of a frame
        if (line_edge && cnt_q >= CNT_FRAME) begin
          state_d   = CELL;
          bit_cnt_d = '0;
          shift_d   = '0;
        end
      end
      CELL, MID: begin
        if (line_edge) begin
          if (edge_class == ILLEGAL || (state_q == MID && edge_class == LONG)) begin
            code_error_d = 1'b1;
            state_d      = CELL;
            bit_cnt_d    = '0;
            shift_d      = '0;
          end else if (state_q == CELL && edge_class == SHORT) begin
            state_d = MID;
          end else begin
            bit_strobe = 1'b1;
            bit_value  = (state_q == MID);
            state_d    = CELL;
          end
        end else if (cnt_d == CNT_SAT) begin
          state_d       = IDLE;
          frame_error_d = (bit_cnt_q != '0) || (state_q == MID);
          bit_cnt_d     = '0;
          shift_d       = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // bits enter at the top so the first decoded bit ends up in bit 0
    if (bit_strobe) begin
      shift_d = {bit_value, shift_q[WIDTH-1:1]};
      if (bit_cnt_q == LAST_BIT) begin
        bit_cnt_d = '0;
        done_d    = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
      end
    end
  end

  always_comb begin
    handshake  = rx_valid_q && rx_ready;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (handshake) begin
      rx_valid_d = 1'b0;
    end
    if (done_q) begin
      if (!rx_valid_q || handshake) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      done_q        <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      overrun_q     <= 1'b0;
      code_error_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      done_q        <= done_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      overrun_q     <= overrun_d;
      code_error_q  <= code_error_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign overrun     = overrun_q;
  assign code_error  = code_error_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_bmc_receiver.sv
// tb/tb_bmc_receiver.sv - scoreboard bench for bmc_receiver with WIDTH=16, OSR=8
module tb_bmc_receiver;
  import bmc_pkg::*;

  localparam int WIDTH = 16;
  localparam int OSR   = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             serial_in;
  logic             rx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             overrun;
  logic             code_error;
  logic             frame_error;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  int ce_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int s_valid, s_ce, s_fe, s_ov;
  int k_seen;
  logic [WIDTH-1:0] exp_q[$];

  always #5 clock = ~clock;

  bmc_receiver #(.WIDTH(WIDTH), .OSR(OSR)) dut (
    .clock       (clock),
    .reset       (reset),
    .serial_in   (serial_in),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .overrun     (overrun),
    .code_error  (code_error),
    .frame_error (frame_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic snap();
    s_valid = valid_cycles;
    s_ce    = ce_cnt;
    s_fe    = fe_cnt;
    s_ov    = ov_cnt;
  endtask

  // jit_mode 0: nominal cells, 1: random +/-2 per cell, 2: every cell +3
  task automatic send_word(input logic [15:0] w, input int nbits, input bit lead,
                           input int jit_mode, input int glitch_bit);
    int j, len, h1;
    if (lead) serial_in = ~serial_in;
    for (int i = 0; i < nbits; i++) begin
      j = 0;
      if (jit_mode == 1) j = int'($urandom_range(4, 0)) - 2;
      else if (jit_mode == 2) j = 3;
      len = OSR + j;
      if (w[i]) begin
        h1 = len / 2;
        tick(h1);
        serial_in = ~serial_in;
        tick(len - h1);
        serial_in = ~serial_in;
      end else begin
        tick((i == glitch_bit) ? 1 : len);
        serial_in = ~serial_in;
      end
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) valid_cycles++;
      if (code_error) ce_cnt++;
      if (frame_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (rx_valid && rx_ready) begin
        check_eq("word_expected", 32'(exp_q.size() > 0), 32'(1));
        if (exp_q.size() > 0) check_eq("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    serial_in = 1'b0;
    rx_ready  = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_rx_valid", 32'(rx_valid), 32'(0));
    check_eq("rst_rx_data", 32'(rx_data), 32'(0));
    check_eq("rst_overrun", 32'(overrun), 32'(0));
    check_eq("rst_code_error", 32'(code_error), 32'(0));
    check_eq("rst_frame_error", 32'(frame_error), 32'(0));
    check_eq("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clock);
    #1 reset = 1'b0;

    // single word, consumer always ready
    tick(20);
    snap();
    exp_q.push_back(16'hA5C3);
    send_word(16'hA5C3, 16, 1'b1, 0, -1);
    tick(30);
    check_eq("t1_valid_cycles", 32'(valid_cycles - s_valid), 32'(1));
    check_eq("t1_code_error", 32'(ce_cnt - s_ce), 32'(0));
    check_eq("t1_frame_error", 32'(fe_cnt - s_fe), 32'(0));
    check_eq("t1_overrun", 32'(ov_cnt - s_ov), 32'(0));
    check_eq("t1_queue_empty", 32'(exp_q.size()), 32'(0));

    // back-to-back words with a stalled consumer
    rx_ready = 1'b0;
    snap();
    exp_q.push_back(16'h0001);
    send_word(16'h0001, 16, 1'b1, 0, -1);
    send_word(16'hFFFF, 16, 1'b0, 0, -1);
    tick(30);
    check_eq("t2_rx_valid_held", 32'(rx_valid), 32'(1));
    check_eq("t2_rx_data_held", 32'(rx_data), 32'(16'h0001));
    check_eq("t2_overrun", 32'(ov_cnt - s_ov), 32'(1));
    check_eq("t2_code_error", 32'(ce_cnt - s_ce), 32'(0));
    rx_ready = 1'b1;
    tick(3);
    check_eq("t2_rx_valid_drop", 32'(rx_valid), 32'(0));
    check_eq("t2_queue_empty", 32'(exp_q.size()), 32'(0));

    // one-cycle interval in place of bit 3
    snap();
    send_word(16'h1234, 16, 1'b1, 0, 3);
    tick(30);
    check_eq("t3_code_error", 32'(ce_cnt - s_ce), 32'(1));
    check_eq("t3_no_valid", 32'(valid_cycles - s_valid), 32'(0));
    check_eq("t3_frame_error", 32'(fe_cnt - s_fe), 32'(1));

    // line stops after 7 bits
    snap();
    send_word(16'h0055, 7, 1'b1, 0, -1);
    k_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (frame_error && k_seen == 0) k_seen = k;
    end
    check_eq("t4_frame_error_latency", 32'(k_seen), 32'(3 + 2 * OSR + 1));
    check_eq("t4_frame_error_count", 32'(fe_cnt - s_fe), 32'(1));
    check_eq("t4_state", 32'(dut.state_q), 32'(IDLE));
    check_eq("t4_no_valid", 32'(valid_cycles - s_valid), 32'(0));

    // jitter within tolerance
    snap();
    exp_q.push_back(16'h5AA5);
    send_word(16'h5AA5, 16, 1'b1, 1, -1);
    tick(30);
    check_eq("t5_valid_cycles", 32'(valid_cycles - s_valid), 32'(1));
    check_eq("t5_code_error", 32'(ce_cnt - s_ce), 32'(0));
    check_eq("t5_frame_error", 32'(fe_cnt - s_fe), 32'(0));
    check_eq("t5_queue_empty", 32'(exp_q.size()), 32'(0));

    // jitter beyond tolerance
    snap();
    send_word(16'h5AA5, 16, 1'b1, 2, -1);
    tick(30);
    check_eq("t5_jit3_code_error", 32'((ce_cnt - s_ce) > 0), 32'(1));
    check_eq("t5_jit3_no_valid", 32'(valid_cycles - s_valid), 32'(0));

    // reset mid-word with a pending word in the output slot
    rx_ready = 1'b0;
    snap();
    exp_q.push_back(16'h1111);
    send_word(16'h1111, 16, 1'b1, 0, -1);
    tick(30);
    check_eq("t6_pending_valid", 32'(rx_valid), 32'(1));
    send_word(16'hC0DE, 9, 1'b1, 0, -1);
    tick(3);
    @(posedge clock);
    #3 reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    check_eq("t6_rst_rx_valid", 32'(rx_valid), 32'(0));
    check_eq("t6_rst_rx_data", 32'(rx_data), 32'(0));
    check_eq("t6_rst_pulses", 32'({overrun, code_error, frame_error}), 32'(0));
    repeat (2) @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    rx_ready = 1'b1;
    tick(25);
    exp_q.push_back(16'hBEEF);
    send_word(16'hBEEF, 16, 1'b1, 0, -1);
    tick(30);
    check_eq("t6_code_error", 32'(ce_cnt - s_ce), 32'(0));
    check_eq("t6_frame_error", 32'(fe_cnt - s_fe), 32'(0));
    check_eq("t6_overrun", 32'(ov_cnt - s_ov), 32'(0));
    check_eq("t6_queue_empty", 32'(exp_q.size()), 32'(0));
    check_eq("t6_rx_data_last", 32'(rx_data), 32'(16'hBEEF));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
